// File: rtl/irq_pending_latch.sv
//============================================================================
// Module      : irq_pending_latch
// Description : Four-line interrupt pending latch. A rising edge on a request
//               line latches that line; an acknowledge strobe clears the
//               addressed line. Each line also has a sticky overrun flag that
//               records a new edge arriving while the line is still latched.
//               The mask hides lines from pending/irq without blocking the
//               latching itself.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk      in   1  single clock, all state updates on rising edge
//   rst_n    in   1  asynchronous active-low reset
//   req      in   4  raw request lines (rising edge posts a request)
//   mask     in   4  1 hides a line from pending/irq (does not block latching)
//   ack      in   1  acknowledge strobe
//   ack_id   in   2  index of the line acknowledged when ack=1
//   pending  out  4  latched & ~mask, feeds the downstream priority encoder
//   irq      out  1  OR-reduction of pending
//   overrun  out  4  sticky per-line overrun flags
//----------------------------------------------------------------------------
// Configuration macro
//   IRQ_PENDING_SYNC_EN : when defined, req passes through a 2-flop
//                         synchronizer per line before edge detection
//                         (request-to-latched latency becomes 3 edges).
//                         When undefined, req feeds edge detection directly
//                         (1-edge latency).
//============================================================================
`default_nettype none

module irq_pending_latch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic       ack,
  input  logic [1:0] ack_id,
  output logic [3:0] pending,
  output logic       irq,
  output logic [3:0] overrun
);

  localparam int unsigned N_LINES = 4;

  logic [N_LINES-1:0] edge_in;    // request lines as seen by the edge detector
  logic [N_LINES-1:0] req_edge;   // one-cycle rising-edge pulses
  logic [N_LINES-1:0] ack_hit;    // one-hot decode of the acknowledge

  logic [N_LINES-1:0] req_q,     req_d;
  logic [N_LINES-1:0] latched_q, latched_d;
  logic [N_LINES-1:0] overrun_q, overrun_d;

`ifdef IRQ_PENDING_SYNC_EN
  logic [N_LINES-1:0] sync1_q, sync1_d;
  logic [N_LINES-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = req;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign edge_in = sync2_q;
`else
  assign edge_in = req;
`endif

  always_comb begin
    ack_hit = '0;
    if (ack) begin
      ack_hit[ack_id] = 1'b1;
    end

    req_d    = edge_in;
    req_edge = edge_in & ~req_q;

    // Set has priority over clear: a fresh edge keeps the line latched even
    // when it is acknowledged in the same cycle.
    latched_d = req_edge | (latched_q & ~ack_hit);

    // Overrun only when an edge lands on an already-latched line that is not
    // being acknowledged right now; an ack otherwise clears the flag.
    overrun_d = (req_edge & latched_q & ~ack_hit) | (overrun_q & ~ack_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // All-ones history so a line already high when reset releases is not
      // mistaken for a rising edge.
      req_q     <= '1;
      latched_q <= '0;
      overrun_q <= '0;
    end else begin
      req_q     <= req_d;
      latched_q <= latched_d;
      overrun_q <= overrun_d;
    end
  end

  // Purely combinational so mask changes are visible in the same cycle.
  assign pending = latched_q & ~mask;
  assign irq     = |pending;
  assign overrun = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_pending_latch.sv
//============================================================================
// Module      : tb_irq_pending_latch
// Description : Directed scoreboard bench for irq_pending_latch (default
//               build, synchronizer macro undefined). Stimulus pushes the
//               hand-computed expected outputs into a queue and signals a
//               sample point; an independent monitor pops and compares.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_irq_pending_latch;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] mask;
  logic       ack;
  logic [1:0] ack_id;
  logic [3:0] pending;
  logic       irq;
  logic [3:0] overrun;

  irq_pending_latch dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mask    (mask),
    .ack     (ack),
    .ack_id  (ack_id),
    .pending (pending),
    .irq     (irq),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: {pending, irq, overrun} plus a label per entry.
  logic [8:0] exp_q[$];
  string      name_q[$];
  event       sample_ev;
  int         vectors;
  int         miscompares;

  initial begin
    vectors     = 0;
    miscompares = 0;
  end

  // Monitor: every sample point pops one expectation and compares.
  initial begin
    logic [8:0] e;
    string      n;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sample_without_expectation: actual p=%b irq=%b ovr=%b required none", pending, irq, overrun);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        vectors++;
        if ({pending, irq, overrun} !== e) begin
          miscompares++;
          $display("FAIL %s: actual p=%b irq=%b ovr=%b required p=%b irq=%b ovr=%b",
                   n, pending, irq, overrun, e[8:5], e[4], e[3:0]);
        end
      end
    end
  end

  task automatic expect_out(input string n, input logic [3:0] p, input logic i, input logic [3:0] o);
    exp_q.push_back({p, i, o});
    name_q.push_back(n);
    -> sample_ev;
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] m, input logic a, input logic [1:0] id);
    @(negedge clk);
    req    = r;
    mask   = m;
    ack    = a;
    ack_id = id;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req = 4'b0000; mask = 4'b0000; ack = 1'b0; ack_id = 2'd0;
    #2;
    expect_out("reset_state", 4'b0000, 1'b0, 4'b0000);
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();

    // Single rising edge: invisible before the edge, latched after it.
    drive(4'b0100, 4'b0000, 1'b0, 2'd0);
    expect_out("before_edge", 4'b0000, 1'b0, 4'b0000);
    tick();
    expect_out("edge_latency", 4'b0100, 1'b1, 4'b0000);

    // Build latched=0101, then acknowledge line 2 then line 0.
    drive(4'b0001, 4'b0000, 1'b0, 2'd0); tick();
    expect_out("latched_0101", 4'b0101, 1'b1, 4'b0000);
    drive(4'b0000, 4'b0000, 1'b1, 2'd2); tick();
    expect_out("ack_line2", 4'b0001, 1'b1, 4'b0000);
    drive(4'b0000, 4'b0000, 1'b1, 2'd0); tick();
    expect_out("ack_line0", 4'b0000, 1'b0, 4'b0000);
    drive(4'b0000, 4'b0000, 1'b1, 2'd1); tick();
    expect_out("ack_noop", 4'b0000, 1'b0, 4'b0000);

    // Overrun on line 3: pulse twice without acknowledge.
    drive(4'b1000, 4'b0000, 1'b0, 2'd0); tick();
    expect_out("line3_set", 4'b1000, 1'b1, 4'b0000);
    drive(4'b0000, 4'b0000, 1'b0, 2'd0); tick();
    drive(4'b1000, 4'b0000, 1'b0, 2'd0); tick();
    expect_out("line3_overrun", 4'b1000, 1'b1, 4'b1000);
    drive(4'b0000, 4'b0000, 1'b1, 2'd3); tick();
    expect_out("line3_ack_clears", 4'b0000, 1'b0, 4'b0000);

    // Set beats clear: edge on line 1 together with its acknowledge.
    drive(4'b0010, 4'b0000, 1'b0, 2'd0); tick();
    expect_out("line1_set", 4'b0010, 1'b1, 4'b0000);
    drive(4'b0000, 4'b0000, 1'b0, 2'd0); tick();
    drive(4'b0010, 4'b0000, 1'b1, 2'd1); tick();
    expect_out("set_beats_ack", 4'b0010, 1'b1, 4'b0000);

    // Level held high does not re-latch after acknowledge.
    drive(4'b0010, 4'b0000, 1'b1, 2'd1); tick();
    expect_out("ack_with_level_high", 4'b0000, 1'b0, 4'b0000);
    drive(4'b0010, 4'b0000, 1'b0, 2'd0); tick(); tick();
    expect_out("level_no_relatch", 4'b0000, 1'b0, 4'b0000);

    // Masking hides but does not block latching; unmask is immediate.
    drive(4'b0000, 4'b1111, 1'b0, 2'd0); tick();
    drive(4'b1111, 4'b1111, 1'b0, 2'd0); tick();
    expect_out("all_masked", 4'b0000, 1'b0, 4'b0000);
    mask = 4'b0000;
    #1;
    expect_out("unmask_same_cycle", 4'b1111, 1'b1, 4'b0000);
    drive(4'b0000, 4'b0000, 1'b0, 2'd0); tick();
    drive(4'b0001, 4'b0000, 1'b0, 2'd0); tick();
    expect_out("overrun_line0", 4'b1111, 1'b1, 4'b0001);
    drive(4'b0000, 4'b0100, 1'b1, 2'd1); tick();
    expect_out("ack1_independent", 4'b1001, 1'b1, 4'b0001);
    drive(4'b0000, 4'b0000, 1'b1, 2'd0); tick();
    expect_out("ack0_clears_ovr", 4'b1100, 1'b1, 4'b0000);
    drive(4'b0000, 4'b0000, 1'b1, 2'd2); tick();
    drive(4'b0000, 4'b0000, 1'b1, 2'd3); tick();
    expect_out("all_acked", 4'b0000, 1'b0, 4'b0000);

    // Lines held high through reset release must not post requests.
    drive(4'b1111, 4'b0000, 1'b0, 2'd0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    expect_out("reset_with_req_high", 4'b0000, 1'b0, 4'b0000);
    @(negedge clk); rst_n = 1'b1;
    tick(); tick(); tick();
    expect_out("held_high_no_post", 4'b0000, 1'b0, 4'b0000);

    // Asynchronous reset mid-cycle discards state before the next edge.
    drive(4'b0000, 4'b0000, 1'b0, 2'd0); tick();
    drive(4'b0011, 4'b0000, 1'b0, 2'd0); tick();
    expect_out("latched_0011", 4'b0011, 1'b1, 4'b0000);
    drive(4'b0000, 4'b0000, 1'b0, 2'd0); tick();
    drive(4'b0011, 4'b0000, 1'b0, 2'd0); tick();
    expect_out("overrun_0011", 4'b0011, 1'b1, 4'b0011);
    #1;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset_clear", 4'b0000, 1'b0, 4'b0000);
    @(negedge clk); rst_n = 1'b1;
    tick();

    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: actual %0d left required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
